// File: rtl/riscv_lsu.sv
// Load/store unit for the RV32I multi-cycle core.
// Serves one request at a time against a single-port synchronous RAM.
// Sub-word stores use read-modify-write.
// Also decodes the LED register and the framebuffer window, and flags
// misaligned or illegal accesses instead of touching memory.
module riscv_lsu #(
    parameter int unsigned ADDR_W    = 13,
    parameter logic [31:0] LED_ADDR  = 32'h0000_7540,
    parameter int unsigned LED_W     = 6,
    parameter logic [31:0] FB_BASE   = 32'h0000_7550,
    parameter int unsigned FB_PIXELS = 2048,
    localparam int unsigned FB_AW    = $clog2(FB_PIXELS)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    output logic [4:0]        rsp_rd,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [LED_W-1:0]  led,
    output logic              fb_we,
    output logic [FB_AW-1:0]  fb_addr,
    output logic              fb_bit
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_CAP  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_RSP  = 3'd4;

    localparam logic [31:0] FB_END = FB_BASE + 32'(FB_PIXELS * 4);

    logic [2:0]       state_q, state_d;
    logic             we_q;
    logic [2:0]       funct3_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [4:0]       rd_q;
    logic             err_q;
    logic [31:0]      cap_q;
    logic [LED_W-1:0] led_q;

    logic             misaligned;
    logic             illegal;
    logic             accept;
    logic [31:0]      byte_lane;
    logic [31:0]      half_lane;
    logic [31:0]      load_data;
    logic [31:0]      merged;
    logic             led_hit;
    logic             fb_hit;
    logic [31:0]      fb_off;

    assign accept = req_valid & (state_q == ST_IDLE);

    // Accept-time legality checks on the incoming request
    always_comb begin
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
        if (req_we) begin
            illegal = (req_funct3 >= 3'd3);
        end else begin
            illegal = (req_funct3 == 3'd3) | (req_funct3 == 3'd6) | (req_funct3 == 3'd7);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (misaligned | illegal) begin
                        state_d = ST_RSP;
                    end else if (req_we && req_funct3 == 3'd2) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD:   state_d = ST_CAP;
            ST_CAP:  state_d = we_q ? ST_WR : ST_RSP;
            ST_WR:   state_d = ST_RSP;
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, request latch, read capture and LED register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rd_q     <= 5'd0;
            err_q    <= 1'b0;
            cap_q    <= 32'd0;
            led_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rd_q     <= req_rd;
                err_q    <= misaligned | illegal;
            end
            if (state_q == ST_CAP) begin
                cap_q <= mem_rdata;
            end
            if (state_q == ST_WR && led_hit) begin
                led_q <= wdata_q[LED_W-1:0];
            end
        end
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        byte_lane = cap_q >> {addr_q[1:0], 3'b000};
        half_lane = cap_q >> {addr_q[1], 4'b0000};
        case (funct3_q)
            3'd0:    load_data = {{24{byte_lane[7]}}, byte_lane[7:0]};
            3'd1:    load_data = {{16{half_lane[15]}}, half_lane[15:0]};
            3'd2:    load_data = cap_q;
            3'd4:    load_data = {24'd0, byte_lane[7:0]};
            3'd5:    load_data = {16'd0, half_lane[15:0]};
            default: load_data = 32'd0;
        endcase
        merged = cap_q;
        case (funct3_q[1:0])
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // MMIO decode on the latched byte address (full 32-bit compare, no wrap)
    always_comb begin
        led_hit = (addr_q[31:2] == LED_ADDR[31:2]);
        fb_hit  = (addr_q >= FB_BASE) && (addr_q < FB_END);
        fb_off  = addr_q - FB_BASE;
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RSP);
    assign rsp_rd    = rd_q;
    assign rsp_err   = (state_q == ST_RSP) & err_q;
    assign rsp_data  = (state_q == ST_RSP && !err_q && !we_q) ? load_data : 32'd0;

    // Upper address bits are dropped so accesses wrap modulo the RAM size
    assign mem_addr  = addr_q[ADDR_W+1:2];
    assign mem_we    = (state_q == ST_WR);
    assign mem_wdata = (state_q == ST_WR) ? merged : 32'd0;

    assign led       = led_q;
    assign fb_we     = (state_q == ST_WR) & fb_hit;
    assign fb_addr   = fb_we ? FB_AW'(fb_off >> 2) : '0;
    assign fb_bit    = fb_we & wdata_q[0];

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: a request-level model predicts latency,
// RAM writes, MMIO side effects and responses; a negedge process compares.
module tb_riscv_lsu;

    localparam int unsigned   ADDR_W    = 13;
    localparam int unsigned   LED_W     = 6;
    localparam int unsigned   FB_PIXELS = 2048;
    localparam int unsigned   FB_AW     = 11;
    localparam logic [31:0]   LED_ADDR  = 32'h0000_7540;
    localparam logic [31:0]   FB_BASE   = 32'h0000_7550;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              req_valid, req_ready, req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr, req_wdata;
    logic [4:0]        req_rd;
    logic              rsp_valid, rsp_err;
    logic [4:0]        rsp_rd;
    logic [31:0]       rsp_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata, mem_rdata;
    logic [LED_W-1:0]  led;
    logic              fb_we, fb_bit;
    logic [FB_AW-1:0]  fb_addr;

    always #5 sys_clk = ~sys_clk;

    riscv_lsu #(
        .ADDR_W    (ADDR_W),
        .LED_ADDR  (LED_ADDR),
        .LED_W     (LED_W),
        .FB_BASE   (FB_BASE),
        .FB_PIXELS (FB_PIXELS)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .rsp_valid  (rsp_valid),
        .rsp_rd     (rsp_rd),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .led        (led),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_bit     (fb_bit)
    );

    // Synchronous single-port RAM seen by the DUT
    logic [31:0] ram [0:8191];
    always @(posedge sys_clk) begin
        if (sys_rst_n && mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state
    logic [31:0] mdl [0:8191];
    bit          busy = 0;
    int          since, e_lat, e_wr;
    int          done_cnt = 0;
    logic [12:0] e_widx;
    logic [31:0] e_new, e_data, e_fbaddr;
    logic [4:0]  e_rd;
    logic        e_err, e_led, e_fb, e_fbbit;
    logic [LED_W-1:0] e_ledval;
    logic [LED_W-1:0] model_led = '0;
    logic [31:0] last_data;
    logic        last_err;

    // Per-cycle comparison against the request-level model
    always @(negedge sys_clk) begin : cmp
        bit          was_busy, exp_v, exp_we;
        logic [31:0] old, b, h, mask;
        int          sh;
        bit          mis, ill;
        if (!sys_rst_n) begin
            busy      = 0;
            model_led = '0;
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_fb_we", fb_we, 0);
            check("rst_req_ready", req_ready, 1);
            check("rst_led", led, 0);
        end else begin
            was_busy = busy;
            if (busy) since++;
            exp_v  = busy && since == e_lat;
            exp_we = busy && e_wr != 0 && since == e_wr;
            check("req_ready", req_ready, !was_busy);
            check("rsp_valid", rsp_valid, exp_v);
            check("mem_we", mem_we, exp_we);
            check("fb_we", fb_we, exp_we && e_fb);
            check("led", led, model_led);
            if (exp_we) begin
                check("mem_addr", mem_addr, e_widx);
                check("mem_wdata", mem_wdata, e_new);
                mdl[e_widx] = e_new;
                if (e_led) model_led = e_ledval;
                if (e_fb) begin
                    check("fb_addr", fb_addr, e_fbaddr);
                    check("fb_bit", fb_bit, e_fbbit);
                end
            end
            if (exp_v) begin
                check("rsp_rd", rsp_rd, e_rd);
                check("rsp_data", rsp_data, e_data);
                check("rsp_err", rsp_err, e_err);
                last_data = rsp_data;
                last_err  = rsp_err;
                busy = 0;
                done_cnt++;
            end
            if (!was_busy && req_valid) begin
                mis = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                      (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
                ill = req_we ? (req_funct3 >= 3'd3)
                             : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
                e_err  = mis || ill;
                e_rd   = req_rd;
                e_widx = 13'((req_addr >> 2) % 8192);
                old    = mdl[e_widx];
                e_data = 0;
                e_wr   = 0;
                e_led  = 0;
                e_fb   = 0;
                e_new  = 0;
                if (e_err) begin
                    e_lat = 1;
                end else if (!req_we) begin
                    e_lat = 3;
                    b = (old >> (8 * req_addr[1:0])) & 32'hFF;
                    h = (old >> (16 * req_addr[1])) & 32'hFFFF;
                    case (req_funct3)
                        3'd0: e_data = b[7] ? (b | 32'hFFFF_FF00) : b;
                        3'd1: e_data = h[15] ? (h | 32'hFFFF_0000) : h;
                        3'd2: e_data = old;
                        3'd4: e_data = b;
                        default: e_data = h;
                    endcase
                end else begin
                    if (req_funct3 == 3'd2) begin
                        e_lat = 2; e_wr = 1; e_new = req_wdata;
                    end else begin
                        e_lat = 4; e_wr = 3;
                        sh    = (req_funct3 == 3'd0) ? 8 * req_addr[1:0] : 16 * req_addr[1];
                        mask  = ((req_funct3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
                        e_new = (old & ~mask) | ((req_wdata << sh) & mask);
                    end
                    e_led    = (req_addr >> 2) == (LED_ADDR >> 2);
                    e_ledval = req_wdata[LED_W-1:0];
                    e_fb     = req_addr >= FB_BASE && req_addr < FB_BASE + 4 * FB_PIXELS;
                    e_fbaddr = (req_addr - FB_BASE) >> 2;
                    e_fbbit  = req_wdata[0];
                end
                busy  = 1;
                since = 0;
            end
        end
    end

    // Issue one request and wait for its response; reports measured latency and strobes
    task automatic do_req(input logic we, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          output int lat, output int weps, output int fbps,
                          output logic [31:0] fa, output logic fbit);
        int  d0, edges;
        bit  ok;
        d0 = done_cnt; weps = 0; fbps = 0; fa = 0; fbit = 0; lat = -1;
        req_valid = 1; req_we = we; req_funct3 = f; req_addr = a; req_wdata = wd; req_rd = rd;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge sys_clk); #1;
            if (busy) begin ok = 1; break; end
        end
        req_valid = 0;
        if (!ok) begin
            check("accept_timeout", 0, 1);
            return;
        end
        edges = 1;
        weps += mem_we;
        if (fb_we) begin fbps++; fa = fb_addr; fbit = fb_bit; end
        ok = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge sys_clk); #1;
            edges++;
            weps += mem_we;
            if (fb_we) begin fbps++; fa = fb_addr; fbit = fb_bit; end
            if (done_cnt != d0) begin ok = 1; break; end
        end
        if (!ok) check("rsp_timeout", 0, 1);
        else lat = edges - 1;
        @(posedge sys_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, weps, fbps;
        logic [31:0] fa;
        logic fbit;
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_rd", rsp_rd, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_we", mem_we, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        check("reset_led", led, 0);
        check("reset_fb_we", fb_we, 0);
        check("reset_fb_addr", fb_addr, 0);
        check("reset_fb_bit", fb_bit, 0);
        sys_rst_n = 1;
        @(posedge sys_clk); #1;

        do_req(1, 3'd2, 32'h100, 32'h1234_5678, 5'd5, lat, weps, fbps, fa, fbit);
        check("sw_lat", lat, 2);
        check("sw_we_pulses", weps, 1);
        do_req(0, 3'd2, 32'h100, 0, 5'd6, lat, weps, fbps, fa, fbit);
        check("lw_lat", lat, 3);
        check("lw_data", last_data, 32'h1234_5678);
        check("lw_err", last_err, 0);

        do_req(1, 3'd0, 32'h101, 32'h0000_00AB, 5'd7, lat, weps, fbps, fa, fbit);
        check("sb_lat", lat, 4);
        do_req(0, 3'd2, 32'h100, 0, 5'd8, lat, weps, fbps, fa, fbit);
        check("sb_ram", last_data, 32'h1234_AB78);
        do_req(0, 3'd0, 32'h101, 0, 5'd9, lat, weps, fbps, fa, fbit);
        check("lb_data", last_data, 32'hFFFF_FFAB);
        do_req(0, 3'd4, 32'h101, 0, 5'd0, lat, weps, fbps, fa, fbit);
        check("lbu_data", last_data, 32'h0000_00AB);

        do_req(1, 3'd1, 32'h102, 32'h0000_8001, 5'd10, lat, weps, fbps, fa, fbit);
        check("sh_lat", lat, 4);
        do_req(0, 3'd2, 32'h100, 0, 5'd11, lat, weps, fbps, fa, fbit);
        check("sh_ram", last_data, 32'h8001_AB78);
        do_req(0, 3'd1, 32'h102, 0, 5'd12, lat, weps, fbps, fa, fbit);
        check("lh_data", last_data, 32'hFFFF_8001);
        do_req(0, 3'd5, 32'h102, 0, 5'd13, lat, weps, fbps, fa, fbit);
        check("lhu_data", last_data, 32'h0000_8001);

        do_req(1, 3'd2, LED_ADDR, 32'h0000_002A, 5'd14, lat, weps, fbps, fa, fbit);
        check("led_value", led, 6'b101010);
        check("led_no_fb", fbps, 0);

        do_req(0, 3'd2, 32'h103, 0, 5'd15, lat, weps, fbps, fa, fbit);
        check("err_lw_lat", lat, 1);
        check("err_lw_err", last_err, 1);
        check("err_lw_data", last_data, 0);
        check("err_lw_we", weps, 0);
        do_req(1, 3'd1, 32'h101, 32'h0000_FFFF, 5'd16, lat, weps, fbps, fa, fbit);
        check("err_sh_lat", lat, 1);
        check("err_sh_err", last_err, 1);
        check("err_sh_we", weps + fbps, 0);
        do_req(0, 3'd3, 32'h100, 0, 5'd17, lat, weps, fbps, fa, fbit);
        check("err_f3_lat", lat, 1);
        check("err_f3_err", last_err, 1);
        check("err_f3_data", last_data, 0);
        check("err_led_kept", led, 6'b101010);

        do_req(1, 3'd2, FB_BASE + 20, 32'h1, 5'd18, lat, weps, fbps, fa, fbit);
        check("fb_pulses", fbps, 1);
        check("fb_addr_val", fa, 5);
        check("fb_bit_val", fbit, 1);
        do_req(1, 3'd2, FB_BASE + 4 * FB_PIXELS, 32'h1, 5'd19, lat, weps, fbps, fa, fbit);
        check("fb_end_pulses", fbps, 0);
        check("fb_end_ram_we", weps, 1);

        // Reset asserted during the CAP cycle of SB @0x100
        req_valid = 1; req_we = 1; req_funct3 = 3'd0; req_addr = 32'h100;
        req_wdata = 32'h55; req_rd = 5'd20;
        begin
            bit ok;
            int rv;
            ok = 0; weps = 0; rv = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge sys_clk); #1;
                if (busy) begin ok = 1; break; end
            end
            req_valid = 0;
            if (!ok) check("rst_accept_timeout", 0, 1);
            @(posedge sys_clk); #1;
            sys_rst_n = 0;
            for (int i = 0; i < 3; i++) begin
                @(posedge sys_clk); #1;
                weps += mem_we;
                rv   += rsp_valid;
            end
            sys_rst_n = 1;
            for (int i = 0; i < 4; i++) begin
                @(posedge sys_clk); #1;
                weps += mem_we;
                rv   += rsp_valid;
            end
            check("midrst_no_rsp", rv, 0);
            check("midrst_no_we", weps, 0);
            check("midrst_ready", req_ready, 1);
            check("midrst_ram", ram[13'h40], 32'h8001_AB78);
            check("midrst_led", led, 0);
            check("midrst_mem_addr", mem_addr, 0);
        end
        do_req(0, 3'd2, 32'h100, 0, 5'd21, lat, weps, fbps, fa, fbit);
        check("post_rst_lw", last_data, 32'h8001_AB78);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
